// File: rtl/compare_pkg.sv
// Shared result encoding for the compare cell and its cascade helper.
package compare_pkg;

    localparam logic [2:0] CMP_EQ = 3'b001;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b100;

    // An undecided cascade ({lt,gt} = 00) means every slice matched.
    function automatic logic [2:0] cascade_to_result(input logic [1:0] lt_gt);
        logic [2:0] res;
        case (lt_gt)
            2'b10:   res = CMP_LT;
            2'b01:   res = CMP_GT;
            default: res = CMP_EQ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/comp_slice.sv
// One bit of the compare cascade: a decision made by a higher slice passes
// through, otherwise this slice's own bit pair decides.
module comp_slice
    import compare_pkg::*;
(
    input  logic a_bit,
    input  logic b_bit,
    input  logic eq_i,
    input  logic lt_i,
    input  logic gt_i,
    output logic eq_o,
    output logic lt_o,
    output logic gt_o
);

    always_comb begin
        eq_o = eq_i;
        lt_o = lt_i;
        gt_o = gt_i;
        if (!(lt_i || gt_i)) begin
            lt_o = ~a_bit & b_bit;
            gt_o = a_bit & ~b_bit;
            eq_o = eq_i & (a_bit == b_bit);
        end
    end

endmodule

// File: rtl/compare_cell.sv
// Registered magnitude comparator: MSB-first cascade of bit slices feeding a
// one-cycle result register.
module compare_cell
    import compare_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter bit SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    logic             signed_mode;
    logic [WIDTH:0]   eq_c;
    logic [WIDTH:0]   lt_c;
    logic [WIDTH:0]   gt_c;
    logic [2:0]       next_res;

    assign signed_mode = SIGNED_EN && is_signed;

    assign eq_c[WIDTH] = 1'b1;
    assign lt_c[WIDTH] = 1'b0;
    assign gt_c[WIDTH] = 1'b0;

    // Swapping the sign bits makes a set sign bit rank below a clear one.
    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        logic a_bit;
        logic b_bit;
        if (i == WIDTH - 1) begin : g_msb
            assign a_bit = signed_mode ? b[i] : a[i];
            assign b_bit = signed_mode ? a[i] : b[i];
        end else begin : g_lsb
            assign a_bit = a[i];
            assign b_bit = b[i];
        end
        comp_slice u_slice (
            .a_bit (a_bit),
            .b_bit (b_bit),
            .eq_i  (eq_c[i+1]),
            .lt_i  (lt_c[i+1]),
            .gt_i  (gt_c[i+1]),
            .eq_o  (eq_c[i]),
            .lt_o  (lt_c[i]),
            .gt_o  (gt_c[i])
        );
    end

    assign next_res = eq_c[0] ? CMP_EQ : cascade_to_result({lt_c[0], gt_c[0]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                eq <= next_res[0];
                lt <= next_res[1];
                gt <= next_res[2];
            end
        end
    end

endmodule

// File: tb/tb_compare_cell.sv
// Self-checking bench: three compare_cell widths (1, 4, 8) driven in lockstep
// and checked against an integer-arithmetic reference model.
module tb_compare_cell;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       is_signed;
    logic [7:0] a_v;
    logic [7:0] b_v;

    logic ov1, eq1, lt1, gt1;
    logic ov4, eq4, lt4, gt4;
    logic ov8, eq8, lt8, gt8;

    logic [2:0] exp1, exp4, exp8;
    int checks;
    int failures;

    compare_cell #(.WIDTH(1), .SIGNED_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_v[0]), .b(b_v[0]),
        .is_signed(is_signed), .out_valid(ov1), .eq(eq1), .lt(lt1), .gt(gt1)
    );
    compare_cell #(.WIDTH(4), .SIGNED_EN(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_v[3:0]), .b(b_v[3:0]),
        .is_signed(is_signed), .out_valid(ov4), .eq(eq4), .lt(lt4), .gt(gt4)
    );
    compare_cell #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_v), .b(b_v),
        .is_signed(is_signed), .out_valid(ov8), .eq(eq8), .lt(lt8), .gt(gt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret the low w bits as integers and compare numerically.
    function automatic logic [2:0] ref_cmp(input logic [7:0] av, input logic [7:0] bv,
                                           input int w, input logic sgn);
        longint x;
        longint y;
        longint m;
        m = longint'(1) << w;
        x = longint'(av) % m;
        y = longint'(bv) % m;
        if (sgn && x >= m / 2) x = x - m;
        if (sgn && y >= m / 2) y = y - m;
        if (x < y) return 3'b010;
        if (x > y) return 3'b100;
        return 3'b001;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] av,
                                 input logic [7:0] bv, input logic sgn);
        @(negedge clk);
        in_valid  = iv;
        a_v       = av;
        b_v       = bv;
        is_signed = sgn;
    endtask

    // One cycle: drive, let the edge happen, check every width against the model.
    task automatic step(input string tag, input logic iv, input logic [7:0] av,
                        input logic [7:0] bv, input logic sgn);
        applyStimulus(iv, av, bv, sgn);
        @(posedge clk);
        #1;
        if (iv) begin
            exp1 = ref_cmp(av, bv, 1, sgn);
            exp4 = ref_cmp(av, bv, 4, sgn);
            exp8 = ref_cmp(av, bv, 8, sgn);
        end
        checkOutput({tag, " w1 valid"}, 32'(ov1), 32'(iv));
        checkOutput({tag, " w4 valid"}, 32'(ov4), 32'(iv));
        checkOutput({tag, " w8 valid"}, 32'(ov8), 32'(iv));
        checkOutput({tag, " w1 result"}, 32'({gt1, lt1, eq1}), 32'(exp1));
        checkOutput({tag, " w4 result"}, 32'({gt4, lt4, eq4}), 32'(exp4));
        checkOutput({tag, " w8 result"}, 32'({gt8, lt8, eq8}), 32'(exp8));
        if (iv) checkOutput({tag, " w4 onehot"}, 32'($countones({gt4, lt4, eq4})), 32'd1);
    endtask

    initial begin
        logic [2:0] w1_expect [4];
        logic [2:0] held4;
        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        a_v       = 8'h00;
        b_v       = 8'h00;
        exp1      = 3'b000;
        exp4      = 3'b000;
        exp8      = 3'b000;
        rst_n     = 1'b0;
        w1_expect = '{3'b001, 3'b100, 3'b010, 3'b001};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset w1", 32'({ov1, gt1, lt1, eq1}), 32'd0);
        checkOutput("reset w4", 32'({ov4, gt4, lt4, eq4}), 32'd0);
        checkOutput("reset w8", 32'({ov8, gt8, lt8, eq8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 unsigned, {b,a} = 0..3 back to back: eq, gt, lt, eq.
        for (int k = 0; k < 4; k++) begin
            step("w1 seq", 1'b1, 8'(k & 1), 8'((k >> 1) & 1), 1'b0);
            checkOutput("w1 seq const", 32'({gt1, lt1, eq1}), 32'(w1_expect[k]));
        end

        // WIDTH=1 signed: a=1 (-1) < b=0; a=0 > b=1.
        step("w1 signed", 1'b1, 8'h01, 8'h00, 1'b1);
        checkOutput("w1 signed lt", 32'(lt1), 32'd1);
        step("w1 signed", 1'b1, 8'h00, 8'h01, 1'b1);
        checkOutput("w1 signed gt", 32'(gt1), 32'd1);

        // WIDTH=8 boundary pairs.
        step("w8 unsigned", 1'b1, 8'h80, 8'h7F, 1'b0);
        checkOutput("w8 80>7F unsigned", 32'({gt8, lt8, eq8}), 32'b100);
        step("w8 signed", 1'b1, 8'h80, 8'h7F, 1'b1);
        checkOutput("w8 80<7F signed", 32'({gt8, lt8, eq8}), 32'b010);
        step("w8 eq", 1'b1, 8'hFF, 8'hFF, 1'b0);
        checkOutput("w8 FF=FF unsigned", 32'({gt8, lt8, eq8}), 32'b001);
        step("w8 eq", 1'b1, 8'hFF, 8'hFF, 1'b1);
        checkOutput("w8 FF=FF signed", 32'({gt8, lt8, eq8}), 32'b001);

        // Hold: valid compare then idle with changed operands.
        step("hold pre", 1'b1, 8'h03, 8'h09, 1'b0);
        held4 = {gt4, lt4, eq4};
        step("hold", 1'b0, 8'h0C, 8'h02, 1'b1);
        checkOutput("hold w4 unchanged", 32'({gt4, lt4, eq4}), 32'(ref_cmp(8'h03, 8'h09, 4, 1'b0)));
        checkOutput("hold w4 vs prev", 32'({gt4, lt4, eq4}), 32'(held4));

        // Mid-stream asynchronous reset, applied between edges.
        step("rst pre", 1'b1, 8'h05, 8'h02, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst w1", 32'({ov1, gt1, lt1, eq1}), 32'd0);
        checkOutput("async rst w4", 32'({ov4, gt4, lt4, eq4}), 32'd0);
        checkOutput("async rst w8", 32'({ov8, gt8, lt8, eq8}), 32'd0);
        exp1 = 3'b000;
        exp4 = 3'b000;
        exp8 = 3'b000;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step("post rst idle", 1'b0, 8'h11, 8'h22, 1'b0);
        step("post rst first", 1'b1, 8'h3A, 8'hC4, 1'b1);

        // Exhaustive WIDTH=4 sweep in both modes, upper bits randomized.
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 256; p++) begin
                step("sweep", 1'b1,
                     {4'($urandom), 4'(p & 15)},
                     {4'($urandom), 4'(p >> 4)}, s[0]);
            end
        end

        // Random traffic with random gaps.
        for (int r = 0; r < 200; r++) begin
            step("random", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
